// File: rtl/stv_edac_pkg.sv
// rtl/stv_edac_pkg.sv - shared SECDED types and codeword-layout helpers
// Purpose : error status enum and constant functions describing the extended
//           Hamming codeword layout (message bits at non-power-of-2 positions).
// Ports   : none (package)
package stv_edac_pkg;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_CORR   = 2'd1,
        ERR_UNCORR = 2'd2
    } err_e;

    // Number of message bits a PWIDTH-bit Hamming code can protect.
    function automatic int secded_fullwidth(input int pwidth);
        return (1 << pwidth) - pwidth - 1;
    endfunction

    // 1-indexed codeword position of message bit m. Each power of two at or
    // below the running position pushes the message bit one slot further up.
    function automatic int secded_msg_pos(input int m, input int pwidth);
        int pos;
        pos = m + 1;
        for (int p = 0; p < pwidth; p++) begin
            if (pos >= (1 << p)) pos = pos + 1;
        end
        return pos;
    endfunction

endpackage

// File: rtl/stv_secded_pipe_if.sv
// rtl/stv_secded_pipe_if.sv - valid/ready stream bundle for the SECDED pipe
// Purpose : groups the input and output stream handshakes and payloads.
// Ports   : in_valid/in_ready/in_mode/in_data/in_parity (producer side),
//           out_valid/out_ready/out_data/out_parity/out_syndrome/out_err (consumer side).
//           master = traffic source/sink, slave = the SECDED block.
interface stv_secded_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int PWIDTH = 6
);
    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [WIDTH-1:0]  in_data;
    logic [PWIDTH:0]   in_parity;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [PWIDTH:0]   out_parity;
    logic [PWIDTH-1:0] out_syndrome;
    logic [1:0]        out_err;

    modport master (
        output in_valid, in_mode, in_data, in_parity, out_ready,
        input  in_ready, out_valid, out_data, out_parity, out_syndrome, out_err
    );

    modport slave (
        input  in_valid, in_mode, in_data, in_parity, out_ready,
        output in_ready, out_valid, out_data, out_parity, out_syndrome, out_err
    );
endinterface

// File: rtl/stv_secded_parity.sv
// rtl/stv_secded_parity.sv - combinational extended-Hamming parity generator
// Purpose : data -> {overall, hamming[PWIDTH-1:0]} with inverted (odd) parity.
// Ports   : data   in  WIDTH     message (implicitly zero-padded)
//           parity out PWIDTH+1  {overall, hamming}
module stv_secded_parity
    import stv_edac_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int PWIDTH = 6
) (
    input  logic [WIDTH-1:0] data,
    output logic [PWIDTH:0]  parity
);

    // Each set message bit toggles exactly the Hamming bits named by its position.
    logic [PWIDTH-1:0] contrib [WIDTH];
    logic [PWIDTH-1:0] ham;

    for (genvar m = 0; m < WIDTH; m++) begin : g_msg
        localparam int POS = secded_msg_pos(m, PWIDTH);
        assign contrib[m] = data[m] ? POS[PWIDTH-1:0] : '0;
    end

    always_comb begin
        ham = '1;
        for (int m = 0; m < WIDTH; m++) begin
            ham = ham ^ contrib[m];
        end
    end

    assign parity = {~((^data) ^ (^ham)), ham};

endmodule

// File: rtl/stv_secded_pipe.sv
// rtl/stv_secded_pipe.sv - 2-stage SECDED encode/decode pipeline with error counters
// Purpose : per beat, encode (data -> parity) or decode (data+parity -> corrected
//           data + status); saturating counts of corrected/uncorrectable beats.
// Ports   : clk, rst_n (async active-low)
//           bus        stream bundle (slave side)
//           cnt_clr    in  synchronous clear of both counters
//           cnt_corr   out corrected-beat count
//           cnt_uncorr out uncorrectable-beat count
module stv_secded_pipe
    import stv_edac_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int PWIDTH = 6,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    stv_secded_pipe_if.slave  bus,
    input  logic              cnt_clr,
    output logic [CWIDTH-1:0] cnt_corr,
    output logic [CWIDTH-1:0] cnt_uncorr
);

    localparam int FULLWIDTH = secded_fullwidth(PWIDTH);
    localparam int NPOS      = FULLWIDTH + PWIDTH;

    if (FULLWIDTH < WIDTH) begin : g_width_check
        $fatal(1, "stv_secded_pipe: WIDTH exceeds FULLWIDTH for this PWIDTH");
    end

    logic              s1_valid;
    logic [WIDTH-1:0]  s1_data;
    logic [PWIDTH-1:0] s1_syn;
    logic              s1_ov;

    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;
    logic [PWIDTH:0]   out_par_q;
    logic [PWIDTH-1:0] out_syn_q;
    err_e              out_err_q;

    logic              advance;
    logic              out_fire;
    logic [PWIDTH:0]   chk_par;
    logic [PWIDTH-1:0] raw_syn;
    logic [WIDTH-1:0]  corr_data;
    err_e              corr_err;
    logic [PWIDTH:0]   corr_par;
    int                syn_i;
    int                npow;
    int                msg_idx;

    // Both stages move together; a full output register only frees up when taken.
    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid || advance;
    assign out_fire     = out_valid_q && bus.out_ready;

    stv_secded_parity #(.WIDTH(WIDTH), .PWIDTH(PWIDTH)) u_chk (
        .data   (bus.in_data),
        .parity (chk_par)
    );

    // Overall mismatch folds the received and recomputed overall bits with the
    // syndrome parity, so it reuses the checker output instead of a second XOR tree.
    assign raw_syn = chk_par[PWIDTH-1:0] ^ bus.in_parity[PWIDTH-1:0];

    always_comb begin
        corr_data = s1_data;
        corr_err  = ERR_NONE;
        syn_i     = int'(s1_syn);
        npow      = 0;
        for (int p = 0; p < PWIDTH; p++) begin
            if (syn_i >= (1 << p)) npow = npow + 1;
        end
        msg_idx = syn_i - npow - 1;

        if (syn_i == 0) begin
            corr_err = s1_ov ? ERR_CORR : ERR_NONE;
        end else if (!s1_ov) begin
            corr_err = ERR_UNCORR;
        end else if ((syn_i & (syn_i - 1)) == 0) begin
            corr_err = ERR_CORR;
        end else if (syn_i > NPOS || msg_idx >= WIDTH) begin
            // Points at a zero pad bit or outside the codeword: cannot be a single flip.
            corr_err = ERR_UNCORR;
        end else begin
            corr_err = ERR_CORR;
            for (int m = 0; m < WIDTH; m++) begin
                if (m == msg_idx) corr_data[m] = ~s1_data[m];
            end
        end
    end

    stv_secded_parity #(.WIDTH(WIDTH), .PWIDTH(PWIDTH)) u_out (
        .data   (corr_data),
        .parity (corr_par)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s1_syn      <= '0;
            s1_ov       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_par_q   <= '0;
            out_syn_q   <= '0;
            out_err_q   <= ERR_NONE;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
                s1_data  <= bus.in_data;
                s1_syn   <= bus.in_mode ? raw_syn : '0;
                s1_ov    <= bus.in_mode & (chk_par[PWIDTH] ^ bus.in_parity[PWIDTH] ^ (^raw_syn));
            end
            if (advance) begin
                out_valid_q <= s1_valid;
                out_data_q  <= corr_data;
                out_par_q   <= corr_par;
                out_syn_q   <= s1_syn;
                out_err_q   <= corr_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (cnt_clr) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (out_fire) begin
            if (out_err_q == ERR_CORR && cnt_corr != '1)
                cnt_corr <= cnt_corr + 1'b1;
            if (out_err_q == ERR_UNCORR && cnt_uncorr != '1)
                cnt_uncorr <= cnt_uncorr + 1'b1;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_parity   = out_par_q;
    assign bus.out_syndrome = out_syn_q;
    assign bus.out_err      = out_err_q;

endmodule

// File: tb/tb_stv_secded_pipe.sv
// tb/tb_stv_secded_pipe.sv - self-checking bench for stv_secded_pipe
module tb_stv_secded_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic [6:0]  p;
        logic [5:0]  s;
        logic [1:0]  e;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cnt_clr = 1'b0, cnt_clr2 = 1'b0;
    logic [15:0] cnt_corr, cnt_uncorr;
    logic [1:0]  cnt_corr2, cnt_uncorr2;

    int    errors = 0;
    int    checks = 0;
    int    acc_cnt = 0;
    beat_t got_q[$];

    always #5 clk = ~clk;

    stv_secded_pipe_if #(.WIDTH(32), .PWIDTH(6)) bus ();
    stv_secded_pipe_if #(.WIDTH(32), .PWIDTH(6)) bus2 ();

    stv_secded_pipe #(.WIDTH(32), .PWIDTH(6), .CWIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_clr(cnt_clr),
        .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
    );

    stv_secded_pipe #(.WIDTH(32), .PWIDTH(6), .CWIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .cnt_clr(cnt_clr2),
        .cnt_corr(cnt_corr2), .cnt_uncorr(cnt_uncorr2)
    );

    // Reference: codeword positions 1..63, message bits at non-powers of two.
    function automatic logic [6:0] m_encode(input logic [31:0] d);
        logic [5:0] acc;
        logic [5:0] ham;
        int k;
        acc = '0;
        k = 0;
        for (int c = 1; c < 64; c++) begin
            if ((c & (c - 1)) != 0) begin
                if (k < 32 && d[k]) acc = acc ^ 6'(c);
                k++;
            end
        end
        ham = ~acc;
        return {1'b1 ^ (^d) ^ (^ham), ham};
    endfunction

    function automatic beat_t m_decode(input logic [31:0] d, input logic [6:0] p);
        logic [6:0]  enc;
        logic [5:0]  syn;
        logic        ov;
        logic [31:0] dc;
        logic [1:0]  e;
        int k;
        enc = m_encode(d);
        syn = enc[5:0] ^ p[5:0];
        ov  = 1'b1 ^ (^d) ^ (^p);
        dc  = d;
        if (syn == 0) e = ov ? 2'd1 : 2'd0;
        else if (!ov) e = 2'd2;
        else if ((syn & (syn - 6'd1)) == 0) e = 2'd1;
        else begin
            k = 0;
            for (int c = 1; c < 64; c++)
                if (c < int'(syn) && (c & (c - 1)) != 0) k++;
            if (k < 32) begin
                dc[k] = ~dc[k];
                e = 2'd1;
            end else e = 2'd2;
        end
        return '{dc, m_encode(dc), syn, e};
    endfunction

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) acc_cnt++;
            if (bus.out_valid && bus.out_ready)
                got_q.push_back('{bus.out_data, bus.out_parity, bus.out_syndrome, bus.out_err});
        end
    end

    // Starts at a falling edge, holds the beat until accepted, returns at the next falling edge.
    task automatic drive_beat(input logic mode, input logic [31:0] d, input logic [6:0] p);
        int n = 0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = mode;
        bus.in_data   = d;
        bus.in_parity = p;
        #1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drive_timeout in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (got_q.size() < n && t < 400) begin
            @(negedge clk);
            #3;
            t++;
        end
    endtask

    task automatic test_reset;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        if ({bus.out_data, bus.out_parity, bus.out_syndrome, bus.out_err, cnt_corr, cnt_uncorr} !== '0) begin
            errors++;
            $display("FAIL reset_regs got data=%h par=%h syn=%h err=%0d corr=%0d uncorr=%0d exp all 0",
                     bus.out_data, bus.out_parity, bus.out_syndrome, bus.out_err, cnt_corr, cnt_uncorr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_encode_zero;
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive_beat(1'b0, 32'h0, 7'h55);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL enc_latency_early out_valid=%b exp=0", bus.out_valid); end
        @(negedge clk);
        #1;
        checks += 2;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL enc_latency out_valid=%b exp=1", bus.out_valid); end
        if ({bus.out_data, bus.out_parity, bus.out_syndrome, bus.out_err} !== {32'h0, 7'h7F, 6'h0, 2'd0}) begin
            errors++;
            $display("FAIL enc_zero got data=%h par=%h syn=%h err=%0d exp 0/7f/0/0",
                     bus.out_data, bus.out_parity, bus.out_syndrome, bus.out_err);
        end
        @(negedge clk);
        got_q.delete();
    endtask

    task automatic test_decode_directed;
        logic [31:0] din[4] = '{32'h0, 32'h1, 32'h3, 32'h0};
        logic [6:0]  pin[4] = '{7'h7F, 7'h7F, 7'h7F, 7'h3F};
        beat_t       exp[4] = '{'{32'h0, 7'h7F, 6'd0, 2'd0}, '{32'h0, 7'h7F, 6'd3, 2'd1},
                                '{32'h3, 7'h79, 6'd6, 2'd2}, '{32'h0, 7'h7F, 6'd0, 2'd1}};
        @(negedge clk);
        got_q.delete();
        for (int i = 0; i < 4; i++) drive_beat(1'b1, din[i], pin[i]);
        bus.in_valid = 1'b0;
        wait_out(4);
        checks++;
        if (got_q.size() != 4) begin errors++; $display("FAIL dir_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL dir_beat[%0d] got %h/%h/%h/%0d exp %h/%h/%h/%0d", i,
                         got_q[i].d, got_q[i].p, got_q[i].s, got_q[i].e, exp[i].d, exp[i].p, exp[i].s, exp[i].e);
            end
        end
        @(negedge clk);
        checks += 2;
        if (cnt_corr !== 16'd2) begin errors++; $display("FAIL dir_cnt_corr got=%0d exp=2", cnt_corr); end
        if (cnt_uncorr !== 16'd1) begin errors++; $display("FAIL dir_cnt_uncorr got=%0d exp=1", cnt_uncorr); end
    endtask

    task automatic test_stall;
        beat_t exp[$];
        int    a0;
        @(negedge clk);
        got_q.delete();
        bus.out_ready = 1'b0;
        a0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    logic [31:0] d;
                    d = $urandom;
                    exp.push_back(m_decode(d, m_encode(d)));
                    drive_beat(1'b1, d, m_encode(d));
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (5) @(negedge clk);
                #3;
                checks += 3;
                if (acc_cnt - a0 != 2) begin errors++; $display("FAIL stall_accepted got=%0d exp=2", acc_cnt - a0); end
                if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
                if (got_q.size() != 0) begin errors++; $display("FAIL stall_leak got=%0d exp=0", got_q.size()); end
                @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        wait_out(4);
        checks++;
        if (got_q.size() != 4) begin errors++; $display("FAIL stall_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL stall_beat[%0d] got data=%h exp data=%h", i, got_q[i].d, exp[i].d);
            end
        end
    endtask

    task automatic test_random;
        beat_t exp[$];
        int    nc = 0, nu = 0, c0, u0;
        bit    done = 0;
        @(negedge clk);
        got_q.delete();
        c0 = cnt_corr;
        u0 = cnt_uncorr;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic        mode;
                    logic [31:0] d;
                    logic [6:0]  p;
                    logic [38:0] cw;
                    mode = 1'($urandom % 2);
                    d = $urandom;
                    p = m_encode(d);
                    if (mode) begin
                        cw = {p, d};
                        for (int f = 0; f < int'($urandom % 3); f++) cw[$urandom % 39] ^= 1'b1;
                        {p, d} = cw;
                        exp.push_back(m_decode(d, p));
                    end else begin
                        p = 7'($urandom);
                        exp.push_back('{d, m_encode(d), 6'd0, 2'd0});
                    end
                    if (exp[i].e == 2'd1) nc++;
                    if (exp[i].e == 2'd2) nu++;
                    drive_beat(mode, d, p);
                    if ($urandom % 4 == 0) begin
                        bus.in_valid = 1'b0;
                        @(negedge clk);
                    end
                end
                bus.in_valid = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom % 3) != 0;
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_out(60);
        checks++;
        if (got_q.size() != 60) begin errors++; $display("FAIL rand_count got=%0d exp=60", got_q.size()); end
        for (int i = 0; i < 60 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL rand_beat[%0d] got %h/%h/%h/%0d exp %h/%h/%h/%0d", i,
                         got_q[i].d, got_q[i].p, got_q[i].s, got_q[i].e, exp[i].d, exp[i].p, exp[i].s, exp[i].e);
            end
        end
        @(negedge clk);
        checks += 2;
        if (int'(cnt_corr) != c0 + nc) begin errors++; $display("FAIL rand_cnt_corr got=%0d exp=%0d", cnt_corr, c0 + nc); end
        if (int'(cnt_uncorr) != u0 + nu) begin errors++; $display("FAIL rand_cnt_uncorr got=%0d exp=%0d", cnt_uncorr, u0 + nu); end
    endtask

    task automatic send2_single_error;
        logic [31:0] d;
        d = $urandom;
        bus2.in_valid  = 1'b1;
        bus2.in_mode   = 1'b1;
        bus2.in_parity = m_encode(d);
        bus2.in_data   = d ^ (32'h1 << ($urandom % 32));
    endtask

    task automatic test_saturate;
        @(negedge clk);
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send2_single_error();
            @(negedge clk);
        end
        bus2.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks += 2;
        if (cnt_corr2 !== 2'd3) begin errors++; $display("FAIL sat_cnt_corr got=%0d exp=3", cnt_corr2); end
        if (cnt_uncorr2 !== 2'd0) begin errors++; $display("FAIL sat_cnt_uncorr got=%0d exp=0", cnt_uncorr2); end
        @(negedge clk);
        send2_single_error();
        @(negedge clk);
        bus2.in_valid = 1'b0;
        @(negedge clk);
        cnt_clr2 = 1'b1;
        @(negedge clk);
        cnt_clr2 = 1'b0;
        #1;
        checks++;
        if (cnt_corr2 !== 2'd0) begin errors++; $display("FAIL clr_wins got=%0d exp=0", cnt_corr2); end
        @(negedge clk);
        send2_single_error();
        @(negedge clk);
        bus2.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (cnt_corr2 !== 2'd1) begin errors++; $display("FAIL post_clr_count got=%0d exp=1", cnt_corr2); end
    endtask

    task automatic test_reset_inflight;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_beat(1'b1, 32'h1, 7'h7F);
        drive_beat(1'b1, 32'h3, 7'h7F);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        if (cnt_corr !== 16'd0 || cnt_uncorr !== 16'd0) begin
            errors++;
            $display("FAIL rst_counters got corr=%0d uncorr=%0d exp 0/0", cnt_corr, cnt_uncorr);
        end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        got_q.delete();
        repeat (4) @(negedge clk);
        #3;
        checks++;
        if (got_q.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard got outputs=%0d out_valid=%b exp 0/0", got_q.size(), bus.out_valid);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_data = '0; bus.in_parity = '0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_mode = 1'b0; bus2.in_data = '0; bus2.in_parity = '0; bus2.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_encode_zero();
        test_decode_directed();
        test_stall();
        test_random();
        test_saturate();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
